mixcolumns_iter: RTL and testbench

Iterative AES-128 MixColumns stage, directly downstream of `shiftrows`. It consumes the 128-bit ShiftRows output and multiplies each 32-bit column by the fixed MixColumns matrix over GF(2^8), one column per clock, behind a valid/ready handshake. A `last_round` bypass passes the state through unchanged for round 10 so the round datapath keeps a constant latency. The output feeds the AddRoundKey XOR.

---
 rtl/mixcolumns_iter.sv | 118 +++++++++++
 tb/tb_mixcolumns_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumns_iter.sv
// Iterative AES-128 MixColumns: one 32-bit column per clock behind a valid/ready
// handshake, with a last-round bypass that keeps the same four-cycle latency.
module mixcolumns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] data_in,
    input  logic         in_valid,
    input  logic         last_round,
    output logic         in_ready,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    logic [1:0]     col_q;
    logic [127:0]   src_q;
    logic           byp_q;
    logic [127:0]   data_out_q;
    logic [127:0]   data_out_d;
    logic           out_valid_q;

    logic [31:0]    src_col [4];
    logic [31:0]    col_in;
    logic [31:0]    col_res;
    logic           accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        m0 = xtime(a0);
        m1 = xtime(a1);
        m2 = xtime(a2);
        m3 = xtime(a3);
        // 3*x is folded in as xtime(x) ^ x
        return {m0 ^ m1 ^ a1 ^ a2 ^ a3,
                a0 ^ m1 ^ m2 ^ a2 ^ a3,
                a0 ^ a1 ^ m2 ^ m3 ^ a3,
                m0 ^ a0 ^ a1 ^ a2 ^ m3};
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign src_col[gi] = src_q[127-32*gi -: 32];
            assign data_out_d[127-32*gi -: 32] =
                (col_q == 2'(gi)) ? col_res : data_out_q[127-32*gi -: 32];
        end
    endgenerate

    assign col_in   = src_col[col_q];
    assign col_res  = byp_q ? col_in : mix_col(col_in);

    // out_ready feeds in_ready combinationally so a held result can be
    // consumed and replaced on the same edge.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            src_q       <= '0;
            byp_q       <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        src_q   <= data_in;
                        byp_q   <= last_round;
                        col_q   <= 2'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    data_out_q <= data_out_d;
                    col_q      <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            src_q   <= data_in;
                            byp_q   <= last_round;
                            col_q   <= 2'd0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Self-checking bench for mixcolumns_iter: known-answer table, handshake corner
// sequences and random blocks against a generic GF(2^8) matrix-product model.
module tb_mixcolumns_iter;

    logic         clk;
    logic         rst_n;
    logic [127:0] data_in;
    logic         in_valid;
    logic         last_round;
    logic         in_ready;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    mixcolumns_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .last_round (last_round),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic         lr;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    // Generic GF(2^8) multiply, reducing by the AES polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        int x = int'(a);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) r = r ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11b;
        end
        return 8'(r);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din, input logic lr);
        int coef [4] = '{2, 3, 1, 1};
        logic [127:0] res = '0;
        logic [7:0]   acc;
        if (lr) return din;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(din[127-32*c-8*k -: 8], coef[(k - r + 4) % 4]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one block with out_ready=1, then verify latency, data and one-cycle valid.
    task automatic run_vec(input string name, input logic [127:0] din, input logic lr,
                           input logic [127:0] exp);
        int lat;
        @(negedge clk);
        chk({name, "_in_ready"}, 128'(in_ready), 128'd1);
        data_in    = din;
        last_round = lr;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'd4);
        chk({name, "_data"}, data_out, exp);
        @(posedge clk); #1;
        chk({name, "_valid_pulse"}, 128'(out_valid), 128'd0);
        $display("block %s: din=%h lr=%0d dout=%h lat=%0d", name, din, lr, data_out, lat);
    endtask

    logic [127:0] bp_in, bp_exp, held, nxt_in, nxt_exp, rnd;
    logic         rlr;

    initial begin
        tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b1,
                   128'hd4d4d4d5_2d26314c_00000000_ffffffff};
        tbl[2] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                   128'h046681e5_e0cb199a_48f8d37a_2806264c};
        tbl[3] = '{128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
                   128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
        tbl[4] = '{128'h00000000_00000000_00000000_00000000, 1'b0,
                   128'h00000000_00000000_00000000_00000000};

        rst_n      = 1'b1;
        in_valid   = 1'b0;
        last_round = 1'b0;
        out_ready  = 1'b0;
        data_in    = '0;
        #2 rst_n = 1'b0;

        // Reset state, held across clock edges and then after release.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_data_out", data_out, 128'd0);
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        for (int i = 0; i < 5; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].din, tbl[i].lr, tbl[i].exp);

        // Backpressure: result must hold while out_ready=0 and a new block is offered.
        bp_in   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
        bp_exp  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
        nxt_in  = tbl[2].din;
        nxt_exp = tbl[2].exp;
        @(negedge clk);
        out_ready  = 1'b0;
        data_in    = bp_in;
        last_round = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        data_in = nxt_in;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", 128'(out_valid), 128'd1);
        chk("bp_data", data_out, bp_exp);
        held = data_out;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_data%0d", i), data_out, bp_exp);
            chk($sformatf("bp_hold_valid%0d", i), 128'(out_valid), 128'd1);
            chk($sformatf("bp_hold_ready%0d", i), 128'(in_ready), 128'd0);
        end
        $display("block backpressure: dout=%h held 10 cycles", held);

        // Back-to-back: release out_ready with the waiting block; consume and accept together.
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready_comb", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid_drop", 128'(out_valid), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_not_early", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        chk("b2b_valid", 128'(out_valid), 128'd1);
        chk("b2b_data", data_out, nxt_exp);
        $display("block back_to_back: dout=%h", data_out);
        @(posedge clk); #1;
        chk("b2b_valid_pulse", 128'(out_valid), 128'd0);

        // Mid-operation reset at col=2, then a clean block.
        @(negedge clk);
        data_in    = tbl[0].din;
        last_round = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_data_out", data_out, 128'd0);
        $display("block mid_reset: dout=%h valid=%0d", data_out, out_valid);
        @(negedge clk) rst_n = 1'b1;
        run_vec("after_rst", tbl[2].din, 1'b0, tbl[2].exp);

        for (int i = 0; i < 24; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rlr = ($urandom_range(0, 3) == 0);
            run_vec($sformatf("rnd%0d", i), rnd, rlr, model(rnd, rlr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
